// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: register-file and trace-entry constants shared by the write-back slice.
// Rev 1.0
`default_nettype none

package grf_wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int TR_DATA_W   = 32;
    localparam int TR_ADDR_W   = 5;
    localparam int TR_PC_W     = 32;
    localparam int TR_W        = TR_PC_W + TR_ADDR_W + TR_DATA_W;
    localparam int TR_DATA_LSB = 0;
    localparam int TR_ADDR_LSB = TR_DATA_LSB + TR_DATA_W;
    localparam int TR_PC_LSB   = TR_ADDR_LSB + TR_ADDR_W;

    // Field order matches the offsets above: pc in the MSBs, data in the LSBs.
    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_ADDR_W-1:0] addr;
        logic [TR_DATA_W-1:0] data;
    } trace_entry_t;

    function automatic trace_entry_t pack_trace(input logic [TR_PC_W-1:0]   pc,
                                                input logic [TR_ADDR_W-1:0] addr,
                                                input logic [TR_DATA_W-1:0] data);
        trace_entry_t e;
        e.pc   = pc;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/grf_trace_fifo.sv
// grf_trace_fifo: synchronous FIFO with valid/ready pop, drop-on-full push and sticky overflow.
// Rev 1.0
`default_nettype none

module grf_trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             ovf_q;

    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign ovf_o   = ovf_q;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_pop     = valid_o & ready_i;
    assign w_push_ok = push_i & (~full_o | w_pop);
    assign w_drop    = push_i & full_o & ~w_pop;

    always_comb begin
        count_d = count_q;
        if (w_push_ok && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: rtl/grf_wb.sv
// grf_wb: W-stage write-back into the 32x32 register file, D-stage read ports with W->D bypass, commit trace FIFO.
// Rev 1.0
`default_nettype none

module grf_wb
    import grf_wb_pkg::*;
#(
    parameter int TRACE_DEPTH = 4,
    parameter int TRACE_AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        w_we,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic [31:0] w_pc,
    input  logic [4:0]  d_ra1,
    input  logic [4:0]  d_ra2,
    output logic [31:0] d_rd1,
    output logic [31:0] d_rd2,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_full,
    output logic        trace_ovf
);

    logic [31:0]     rf_q [32];
    logic            w_byp_en;
    trace_entry_t    w_push_entry;
    logic [TR_W-1:0] w_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= int'(REG_RA); i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_we && (w_addr != REG_ZERO)) begin
            rf_q[w_addr] <= w_data;
        end
    end

    // Bypass is masked while reset is held so reads reflect the cleared file.
    assign w_byp_en = w_we & reset_n;

    always_comb begin
        d_rd1 = rf_q[d_ra1];
        if (d_ra1 == REG_ZERO) begin
            d_rd1 = '0;
        end else if (w_byp_en && (w_addr == d_ra1)) begin
            d_rd1 = w_data;
        end
    end

    always_comb begin
        d_rd2 = rf_q[d_ra2];
        if (d_ra2 == REG_ZERO) begin
            d_rd2 = '0;
        end else if (w_byp_en && (w_addr == d_ra2)) begin
            d_rd2 = w_data;
        end
    end

    assign w_push_entry = pack_trace(w_pc, w_addr, w_data);

    grf_trace_fifo #(
        .WIDTH (TR_W),
        .DEPTH (TRACE_DEPTH),
        .AW    (TRACE_AW)
    ) u_trace_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_we),
        .wdata_i (w_push_entry),
        .ready_i (trace_ready),
        .valid_o (trace_valid),
        .rdata_o (w_head),
        .full_o  (trace_full),
        .ovf_o   (trace_ovf)
    );

    assign trace_pc   = w_head[TR_PC_LSB   +: TR_PC_W];
    assign trace_addr = w_head[TR_ADDR_LSB +: TR_ADDR_W];
    assign trace_data = w_head[TR_DATA_LSB +: TR_DATA_W];

endmodule

`default_nettype wire

// File: tb/tb_grf_wb.sv
// tb_grf_wb: directed vectors and hand sequences for grf_wb.
// Rev 1.0
`default_nettype none

module tb_grf_wb;

    logic        clk;
    logic        reset_n;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic [4:0]  d_ra1;
    logic [4:0]  d_ra2;
    logic [31:0] d_rd1;
    logic [31:0] d_rd2;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        trace_full;
    logic        trace_ovf;

    int checks = 0;
    int errors = 0;

    grf_wb #(.TRACE_DEPTH(4), .TRACE_AW(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_pc        (w_pc),
        .d_ra1       (d_ra1),
        .d_ra2       (d_ra2),
        .d_rd1       (d_rd1),
        .d_rd2       (d_rd2),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_full  (trace_full),
        .trace_ovf   (trace_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic        exp_tv;
        logic [31:0] exp_tpc;
        logic [4:0]  exp_taddr;
        logic [31:0] exp_tdata;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    vec_t vecs [9];
    ent_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input ent_t e);
        chk({name, ".valid"}, {31'd0, trace_valid}, 32'd1);
        chk({name, ".pc"},    trace_pc, e.pc);
        chk({name, ".addr"},  {27'd0, trace_addr}, {27'd0, e.addr});
        chk({name, ".data"},  trace_data, e.data);
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] pc, input logic ready);
        @(negedge clk);
        w_we        = we;
        w_addr      = addr;
        w_data      = data;
        w_pc        = pc;
        trace_ready = ready;
        #1;
    endtask

    task automatic drain(input string name);
        ent_t e;
        for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
            e = exp_q.pop_front();
            chk_head(name, e);
            @(posedge clk);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        chk({name, ".empty"}, {31'd0, trace_valid}, 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data,
                                input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic [31:0] r1, input logic [31:0] r2, input logic tv,
                                input logic [31:0] tpc, input logic [4:0] ta, input logic [31:0] td);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.pc = pc; v.ra1 = ra1; v.ra2 = ra2;
        v.exp_rd1 = r1; v.exp_rd2 = r2; v.exp_tv = tv;
        v.exp_tpc = tpc; v.exp_taddr = ta; v.exp_tdata = td;
        return v;
    endfunction

    initial begin
        ent_t e;

        vecs[0] = mk(1, 8,  32'h12345678, 32'h3000, 8,  0,  32'h12345678, 32'h0,        0, 0,        0,  0);
        vecs[1] = mk(0, 0,  32'h0,        32'h0,    8,  8,  32'h12345678, 32'h12345678, 1, 32'h3000, 8,  32'h12345678);
        vecs[2] = mk(1, 0,  32'hFFFFFFFF, 32'h3004, 0,  8,  32'h0,        32'h12345678, 0, 0,        0,  0);
        vecs[3] = mk(0, 0,  32'h0,        32'h0,    0,  0,  32'h0,        32'h0,        1, 32'h3004, 0,  32'hFFFFFFFF);
        vecs[4] = mk(1, 31, 32'hBFC00008, 32'h3008, 31, 8,  32'hBFC00008, 32'h12345678, 0, 0,        0,  0);
        vecs[5] = mk(1, 8,  32'h000000AA, 32'h300C, 8,  31, 32'h000000AA, 32'hBFC00008, 1, 32'h3008, 31, 32'hBFC00008);
        vecs[6] = mk(0, 8,  32'h00005555, 32'h0,    8,  9,  32'h000000AA, 32'h0,        1, 32'h300C, 8,  32'h000000AA);
        vecs[7] = mk(1, 9,  32'h0000CAFE, 32'h3010, 8,  9,  32'h000000AA, 32'h0000CAFE, 0, 0,        0,  0);
        vecs[8] = mk(0, 0,  32'h0,        32'h0,    9,  31, 32'h0000CAFE, 32'hBFC00008, 1, 32'h3010, 9,  32'h0000CAFE);

        reset_n = 1'b0; w_we = 0; w_addr = 0; w_data = 0; w_pc = 0;
        d_ra1 = 0; d_ra2 = 0; trace_ready = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Mid-cycle reset with a write held on the W inputs.
        drive(1'b1, 5'd5, 32'h0000AAAA, 32'h100, 1'b0);
        d_ra1 = 5'd5;
        @(posedge clk);
        @(negedge clk);
        w_data = 32'h0000DEAD;
        #1;
        chk("pre_reset.bypass", d_rd1, 32'h0000DEAD);
        chk("pre_reset.valid", {31'd0, trace_valid}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("reset.rd1", d_rd1, 32'h0);
        chk("reset.valid", {31'd0, trace_valid}, 32'd0);
        chk("reset.ovf", {31'd0, trace_ovf}, 32'd0);
        chk("reset.full", {31'd0, trace_full}, 32'd0);
        chk("reset.pc", trace_pc, 32'h0);
        w_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset.rd1", d_rd1, 32'h0);

        // Register commit, bypass and $0 masking, with the monitor always ready.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].pc, 1'b1);
            d_ra1 = vecs[i].ra1;
            d_ra2 = vecs[i].ra2;
            #1;
            chk($sformatf("vec%0d.rd1", i), d_rd1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d.rd2", i), d_rd2, vecs[i].exp_rd2);
            chk($sformatf("vec%0d.tvalid", i), {31'd0, trace_valid}, {31'd0, vecs[i].exp_tv});
            chk($sformatf("vec%0d.tpc", i), trace_pc, vecs[i].exp_tpc);
            chk($sformatf("vec%0d.taddr", i), {27'd0, trace_addr}, {27'd0, vecs[i].exp_taddr});
            chk($sformatf("vec%0d.tdata", i), trace_data, vecs[i].exp_tdata);
            @(posedge clk);
        end

        // Fill the FIFO, then overflow it with a fifth write.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k + 1), 32'(32'h11 * (k + 1)), 32'(32'h4000 + 4 * k), 1'b0);
            chk($sformatf("fill%0d.full_pre", k), {31'd0, trace_full}, 32'd0);
            @(posedge clk);
            e.pc = 32'(32'h4000 + 4 * k); e.addr = 5'(k + 1); e.data = 32'(32'h11 * (k + 1));
            exp_q.push_back(e);
        end
        drive(1'b1, 5'd9, 32'd7, 32'h4010, 1'b0);
        chk("fill4.full", {31'd0, trace_full}, 32'd1);
        chk("fill4.ovf", {31'd0, trace_ovf}, 32'd0);
        @(posedge clk);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        d_ra1 = 5'd9;
        #1;
        chk("ovf.rd9", d_rd1, 32'd7);
        chk("ovf.flag", {31'd0, trace_ovf}, 32'd1);
        chk("ovf.full", {31'd0, trace_full}, 32'd1);
        chk_head("ovf.head", exp_q[0]);

        // Push and pop together while full.
        drive(1'b1, 5'd10, 32'h0000A0A0, 32'h4014, 1'b1);
        @(posedge clk);
        void'(exp_q.pop_front());
        e.pc = 32'h4014; e.addr = 5'd10; e.data = 32'h0000A0A0;
        exp_q.push_back(e);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        chk("pushpop.full", {31'd0, trace_full}, 32'd1);
        chk("pushpop.ovf", {31'd0, trace_ovf}, 32'd1);
        chk_head("pushpop.head", exp_q[0]);
        drain("drain1");

        // Six writes with alternating ready, crossing the pointer wrap.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 5'(11 + k), 32'(32'h1000 + k), 32'(32'h5000 + 4 * k), (k % 2) == 0);
            if (((k % 2) == 0) && (exp_q.size() > 0)) begin
                e = exp_q.pop_front();
                chk_head($sformatf("wrap%0d", k), e);
            end
            @(posedge clk);
            e.pc = 32'(32'h5000 + 4 * k); e.addr = 5'(11 + k); e.data = 32'(32'h1000 + k);
            exp_q.push_back(e);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        chk("wrap.full", {31'd0, trace_full}, 32'd1);
        drain("drain2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
